alu_muldiv: RTL and testbench
=============================

ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand/result width in bits (even, at least 4).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port valid_in  input  1  operation request.
REQ-005 The block SHALL have port aluop  input  2  main-decoder op class.
REQ-006 The block SHALL have port funct  input  6  R-type function field.
REQ-007 The block SHALL have ports a, b  input  WIDTH  operands, unsigned unless the op states otherwise.
REQ-008 The block SHALL have port ready  output  1  high when a request can be accepted.
REQ-009 The block SHALL have port valid_out  output  1  one-cycle pulse marking result valid.
REQ-010 The block SHALL have port result  output  WIDTH  operation result.
REQ-011 The block SHALL have port zero  output  1  high when result equals 0; qualified by valid_out.
REQ-012 The block SHALL have port illegal  output  1  high with valid_out for an undecoded funct.
REQ-013 The block SHALL have ports hi, lo  output  WIDTH  architectural HI/LO registers.

Function
REQ-014 The block SHALL accept a request in a cycle where valid_in=1 and ready=1, and SHALL ignore valid_in while ready=0.
REQ-015 The block SHALL decode aluop as follows: 00 = add, 01 = sub, 11 = OR, and 10 = decode funct.
REQ-016 The block SHALL decode funct as follows: 100000 ADD; 100010 SUB; 100100 AND; 100101 OR; 100110 XOR; 100111 NOR; 101010 SLT (signed); 101011 SLTU; 010000 MFHI; 010010 MFLO; 011001 MULTU; 011011 DIVU.
REQ-017 Add and sub SHALL wrap modulo 2^WIDTH; SLT/SLTU SHALL produce 1 or 0, zero-extended.
REQ-018 Single-cycle ops (all except MULTU/DIVU) SHALL assert valid_out with result registered exactly 1 cycle after accept; ready SHALL stay 1, so back-to-back requests are allowed.
REQ-019 The FSM SHALL have states IDLE, MUL, DIV: IDLE->MUL on accepted MULTU; IDLE->DIV on accepted DIVU; MUL/DIV->IDLE after WIDTH iteration cycles.
REQ-020 ready SHALL be 0 in MUL and DIV, and 1 in IDLE.
REQ-021 MULTU SHALL be shift-add, one bit per cycle: {hi,lo} = a*b (2*WIDTH-bit unsigned); it SHALL accept in cycle 0, iterate in cycles 1..WIDTH, and assert valid_out in cycle WIDTH+1 with result = new lo, with hi/lo updating in that same cycle.
REQ-022 DIVU SHALL be restoring, one bit per cycle, with the same timing as MULTU: lo = a/b, hi = a%b, result = new lo.
REQ-023 Division by zero SHALL give lo = all ones and hi = a, with normal latency and illegal=0.
REQ-024 hi/lo SHALL change only on MULTU/DIVU completion; MFHI/MFLO SHALL return the values present at accept.
REQ-025 For an undecoded funct, the block SHALL return result=0 and illegal=1 with 1-cycle latency, leaving hi/lo unchanged.
REQ-026 valid_out SHALL pulse for exactly one cycle per accepted request; illegal SHALL be 0 whenever valid_out=0.
REQ-027 A request presented in the completion cycle of MUL/DIV SHALL NOT be accepted (ready still 0); it SHALL be accepted the following cycle.

Reset
REQ-028 While reset=1 the block SHALL hold state = IDLE, ready=1, valid_out=0, illegal=0, zero=0, result=0, hi=0, lo=0.
REQ-029 Reset asserted during MUL/DIV SHALL abort the operation with no valid_out, and ready SHALL be 1 in the first cycle after reset deasserts.
REQ-030 The block SHALL ignore valid_in in any cycle where reset=1.

Verification
REQ-031 The bench SHALL check: aluop=10, funct=101010, a=0xFFFFFFFF, b=1 -> valid_out next cycle, result=1; the same with funct=101011 -> result=0.
REQ-032 The bench SHALL check: aluop=01, a=5, b=5 -> result=0, zero=1, 1-cycle latency; then a back-to-back ADD 7+8 -> result=15 on the next cycle.
REQ-033 The bench SHALL check: MULTU with a=0xFFFFFFFF, b=2 -> ready=0 for 32 cycles, valid_out at cycle 33, hi=1, lo=0xFFFFFFFE; then MFHI -> result=1.
REQ-034 The bench SHALL check: DIVU with a=100, b=7 -> lo=14, hi=2 at cycle 33; DIVU with a=9, b=0 -> lo=0xFFFFFFFF, hi=9, illegal=0.
REQ-035 The bench SHALL check: funct=111111 with aluop=10 -> result=0, illegal=1 for one cycle, and hi/lo unchanged.
REQ-036 The bench SHALL check: reset pulsed at cycle 10 of a MULTU -> no valid_out, hi=lo=0, ready=1 after reset, and a following ADD completes normally.

Source files
------------

// File: rtl/alu_muldiv.sv
// alu_muldiv: single-cycle ALU with iterative unsigned multiply/divide.
// Ports:
//   clk, reset          - rising-edge clock, synchronous active-high reset
//   valid_in            - request strobe, taken when ready=1
//   aluop, funct        - op class and R-type function field
//   a, b                - operands
//   ready               - request can be accepted (IDLE)
//   valid_out           - one-cycle result strobe
//   result, zero        - result and its zero flag (qualified by valid_out)
//   illegal             - undecoded funct, pulses with valid_out
//   hi, lo              - architectural HI/LO registers
module alu_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [1:0]       aluop,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             valid_out,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   work_hi_q, work_hi_d;
  logic [WIDTH-1:0]   work_lo_q, work_lo_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               valid_q, valid_d;
  logic               zero_q, zero_d;
  logic               illegal_q, illegal_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               ready_q, ready_d;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic               last_iter;
  logic [WIDTH-1:0]   alu_res;
  logic               slt_s;

  // Shift-add step: work_lo holds the remaining multiplier bits, work_hi the
  // running partial product; the carry is shifted back into the top.
  assign mul_sum   = {1'b0, work_hi_q} + {1'b0, (work_lo_q[0] ? opnd_q : '0)};

  // Restoring step: work_hi is the remainder, work_lo shifts the dividend out
  // and the quotient in. No borrow (bit WIDTH clear) means the trial fits.
  // With a zero divisor every trial fits, giving all-ones quotient and hi = a.
  assign div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_ge    = ~div_diff[WIDTH];

  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
  assign slt_s     = ($signed(a) < $signed(b));

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      opnd_q    <= '0;
      work_hi_q <= '0;
      work_lo_q <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      opnd_q    <= opnd_d;
      work_hi_q <= work_hi_d;
      work_lo_q <= work_lo_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      ready_q   <= ready_d;
    end
  end

  // Next-state, decode and datapath control
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    opnd_d    = opnd_q;
    work_hi_d = work_hi_q;
    work_lo_d = work_lo_q;
    result_d  = result_q;
    valid_d   = 1'b0;
    zero_d    = 1'b0;
    illegal_d = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    alu_res   = '0;

    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          valid_d = 1'b1;
          case (aluop)
            2'b00: alu_res = a + b;
            2'b01: alu_res = a - b;
            2'b11: alu_res = a | b;
            2'b10: begin
              case (funct)
                6'b100000: alu_res = a + b;
                6'b100010: alu_res = a - b;
                6'b100100: alu_res = a & b;
                6'b100101: alu_res = a | b;
                6'b100110: alu_res = a ^ b;
                6'b100111: alu_res = ~(a | b);
                6'b101010: alu_res = WIDTH'(slt_s);
                6'b101011: alu_res = WIDTH'(a < b);
                6'b010000: alu_res = hi_q;
                6'b010010: alu_res = lo_q;
                6'b011001: begin
                  valid_d   = 1'b0;
                  state_d   = S_MUL;
                  cnt_d     = '0;
                  opnd_d    = a;
                  work_hi_d = '0;
                  work_lo_d = b;
                end
                6'b011011: begin
                  valid_d   = 1'b0;
                  state_d   = S_DIV;
                  cnt_d     = '0;
                  opnd_d    = b;
                  work_hi_d = '0;
                  work_lo_d = a;
                end
                default: illegal_d = 1'b1;
              endcase
            end
          endcase
          if (valid_d) begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
          end
        end
      end

      S_MUL: begin
        work_hi_d = mul_sum[WIDTH:1];
        work_lo_d = {mul_sum[0], work_lo_q[WIDTH-1:1]};
        cnt_d     = cnt_q + CNT_W'(1);
        if (last_iter) begin
          state_d  = S_IDLE;
          valid_d  = 1'b1;
          hi_d     = work_hi_d;
          lo_d     = work_lo_d;
          result_d = work_lo_d;
          zero_d   = (work_lo_d == '0);
        end
      end

      S_DIV: begin
        work_hi_d = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        work_lo_d = {work_lo_q[WIDTH-2:0], div_ge};
        cnt_d     = cnt_q + CNT_W'(1);
        if (last_iter) begin
          state_d  = S_IDLE;
          valid_d  = 1'b1;
          hi_d     = work_hi_d;
          lo_d     = work_lo_d;
          result_d = work_lo_d;
          zero_d   = (work_lo_d == '0);
        end
      end

      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
  end

  assign ready     = ready_q;
  assign valid_out = valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Bench for alu_muldiv: back-to-back single-cycle vector table, then
// multiply/divide sequences, illegal funct, and reset abort of a multiply.
module tb_alu_muldiv;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid_in;
  logic [1:0]   aluop;
  logic [5:0]   funct;
  logic [W-1:0] a, b;
  logic         ready, valid_out, zero, illegal;
  logic [W-1:0] result, hi, lo;

  int checks = 0;
  int failures = 0;

  alu_muldiv #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .aluop     (aluop),
    .funct     (funct),
    .a         (a),
    .b         (b),
    .ready     (ready),
    .valid_out (valid_out),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input string nm, input logic [1:0] op, input logic [5:0] f,
                         input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] r, input logic z, input logic il);
    vec_t v;
    v.name = nm; v.aluop = op; v.funct = f; v.a = av; v.b = bv;
    v.res = r; v.zero = z; v.ill = il;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue MULTU/DIVU and wait for completion; optionally keep an ADD 7+8
  // pending through the busy period, which must be taken only once idle.
  task automatic run_mc(input string nm, input logic [5:0] f,
                        input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input bit pend);
    int cyc;
    int busy;
    aluop = 2'b10; funct = f; a = av; b = bv; valid_in = 1'b1;
    step();
    if (pend) begin
      aluop = 2'b00; a = 32'd7; b = 32'd8;
    end else begin
      valid_in = 1'b0;
    end
    cyc = 1;
    busy = 0;
    while (!valid_out && cyc < 100) begin
      if (!ready) busy++;
      step();
      cyc++;
    end
    chk({nm, " latency"}, 64'(cyc), 64'd33);
    chk({nm, " busy_cycles"}, 64'(busy), 64'd32);
    chk({nm, " valid_out"}, 64'(valid_out), 64'd1);
    chk({nm, " result"}, 64'(result), 64'(exp_lo));
    chk({nm, " hi"}, 64'(hi), 64'(exp_hi));
    chk({nm, " lo"}, 64'(lo), 64'(exp_lo));
    chk({nm, " illegal"}, 64'(illegal), 64'd0);
    chk({nm, " ready_at_done"}, 64'(ready), 64'd1);
    step();
    if (pend) begin
      valid_in = 1'b0;
      chk({nm, " pending_add_valid"}, 64'(valid_out), 64'd1);
      chk({nm, " pending_add_result"}, 64'(result), 64'd15);
      chk({nm, " pending_add_hi_kept"}, 64'(hi), 64'(exp_hi));
      step();
    end
    chk({nm, " valid_pulse_end"}, 64'(valid_out), 64'd0);
  endtask

  task automatic single(input string nm, input logic [1:0] op, input logic [5:0] f,
                        input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] r, input logic il);
    aluop = op; funct = f; a = av; b = bv; valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    chk({nm, " valid_out"}, 64'(valid_out), 64'd1);
    chk({nm, " result"}, 64'(result), 64'(r));
    chk({nm, " illegal"}, 64'(illegal), 64'(il));
  endtask

  initial begin
    bit saw_valid;

    add_vec("slt_neg1_lt_1",  2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0);
    add_vec("sltu_max_lt_1",  2'b10, 6'b101011, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
    add_vec("sub_5_5",        2'b01, 6'b000000, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0);
    add_vec("add_7_8",        2'b00, 6'b000000, 32'd7, 32'd8, 32'd15, 1'b0, 1'b0);
    add_vec("add_wrap",       2'b00, 6'b111111, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
    add_vec("sub_wrap",       2'b01, 6'b000000, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    add_vec("or_aluop11",     2'b11, 6'b000000, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1'b0);
    add_vec("funct_add",      2'b10, 6'b100000, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0);
    add_vec("funct_sub",      2'b10, 6'b100010, 32'd10, 32'd3, 32'd7, 1'b0, 1'b0);
    add_vec("funct_and",      2'b10, 6'b100100, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0);
    add_vec("funct_or",       2'b10, 6'b100101, 32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF, 1'b0, 1'b0);
    add_vec("funct_xor",      2'b10, 6'b100110, 32'h0000_FFFF, 32'h0000_0F0F, 32'h0000_F0F0, 1'b0, 1'b0);
    add_vec("funct_nor",      2'b10, 6'b100111, 32'hFFFF_0000, 32'h0000_FFF0, 32'h0000_000F, 1'b0, 1'b0);
    add_vec("slt_5_lt_neg1",  2'b10, 6'b101010, 32'd5, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
    add_vec("sltu_5_lt_max",  2'b10, 6'b101011, 32'd5, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    add_vec("mfhi_reset",     2'b10, 6'b010000, 32'd1, 32'd2, 32'd0, 1'b1, 1'b0);
    add_vec("illegal_000001", 2'b10, 6'b000001, 32'd1, 32'd2, 32'd0, 1'b1, 1'b1);

    reset = 1'b1; valid_in = 1'b0; aluop = 2'b00; funct = 6'd0; a = '0; b = '0;
    repeat (3) step();
    chk("reset ready", 64'(ready), 64'd1);
    chk("reset valid_out", 64'(valid_out), 64'd0);
    chk("reset illegal", 64'(illegal), 64'd0);
    chk("reset zero", 64'(zero), 64'd0);
    chk("reset result", 64'(result), 64'd0);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    reset = 1'b0;
    step();

    // Table applied back-to-back: valid_in stays high across all vectors
    foreach (vecs[i]) begin
      aluop = vecs[i].aluop; funct = vecs[i].funct;
      a = vecs[i].a; b = vecs[i].b; valid_in = 1'b1;
      step();
      chk({vecs[i].name, " valid_out"}, 64'(valid_out), 64'd1);
      chk({vecs[i].name, " result"}, 64'(result), 64'(vecs[i].res));
      chk({vecs[i].name, " zero"}, 64'(zero), 64'(vecs[i].zero));
      chk({vecs[i].name, " illegal"}, 64'(illegal), 64'(vecs[i].ill));
      chk({vecs[i].name, " ready"}, 64'(ready), 64'd1);
    end
    valid_in = 1'b0;
    step();
    chk("table valid_out_drop", 64'(valid_out), 64'd0);
    chk("table illegal_drop", 64'(illegal), 64'd0);
    chk("table hi_kept", 64'(hi), 64'd0);
    chk("table lo_kept", 64'(lo), 64'd0);

    run_mc("multu_max_x2", 6'b011001, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE, 1'b0);
    single("mfhi_after_mul", 2'b10, 6'b010000, 32'd0, 32'd0, 32'd1, 1'b0);
    single("mflo_after_mul", 2'b10, 6'b010010, 32'd0, 32'd0, 32'hFFFF_FFFE, 1'b0);

    run_mc("divu_100_7", 6'b011011, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
    single("mfhi_after_div", 2'b10, 6'b010000, 32'd0, 32'd0, 32'd2, 1'b0);

    run_mc("multu_max_sq", 6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_mc("multu_2p16_sq", 6'b011001, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 1'b0);
    chk("multu_2p16_sq zero_flag_gone", 64'(zero), 64'd0);
    run_mc("divu_max_10", 6'b011011, 32'hFFFF_FFFF, 32'd10, 32'd5, 32'h1999_9999, 1'b0);

    run_mc("divu_by_zero", 6'b011011, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF, 1'b0);

    single("illegal_111111", 2'b10, 6'b111111, 32'd3, 32'd4, 32'd0, 1'b1);
    chk("illegal_111111 hi_kept", 64'(hi), 64'd9);
    chk("illegal_111111 lo_kept", 64'(lo), 64'hFFFF_FFFF);
    step();
    chk("illegal_111111 one_cycle", 64'(illegal), 64'd0);
    chk("illegal_111111 valid_drop", 64'(valid_out), 64'd0);

    // Reset in cycle 10 of a multiply, with a request offered during reset
    aluop = 2'b10; funct = 6'b011001; a = 32'd3; b = 32'd5; valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    repeat (9) step();
    chk("abort busy_before_reset", 64'(ready), 64'd0);
    reset = 1'b1;
    aluop = 2'b00; a = 32'd7; b = 32'd8; valid_in = 1'b1;
    step();
    reset = 1'b0;
    valid_in = 1'b0;
    chk("abort ready_after_reset", 64'(ready), 64'd1);
    chk("abort valid_out", 64'(valid_out), 64'd0);
    chk("abort hi", 64'(hi), 64'd0);
    chk("abort lo", 64'(lo), 64'd0);
    chk("abort result", 64'(result), 64'd0);
    saw_valid = 1'b0;
    repeat (40) begin
      step();
      if (valid_out) saw_valid = 1'b1;
    end
    chk("abort no_late_valid", 64'(saw_valid), 64'd0);
    chk("abort ready_idle", 64'(ready), 64'd1);
    single("add_after_abort", 2'b00, 6'b000000, 32'd7, 32'd8, 32'd15, 1'b0);
    chk("add_after_abort hi", 64'(hi), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
